// File: rtl/present_sched_pkg.sv
// rtl/present_sched_pkg.sv - shared types and widths for the PRESENT job scheduler
package present_sched_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [BLOCK_W-1:0] block;
    logic [KEY_W-1:0]   key;
    logic               encdec;
    logic               id;
  } job_t;

endpackage

// File: rtl/present_scheduler_if.sv
// rtl/present_scheduler_if.sv - request, core and response signals of the scheduler
interface present_scheduler_if;
  import present_sched_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [BLOCK_W-1:0] req_block0;
  logic [BLOCK_W-1:0] req_block1;
  logic [KEY_W-1:0]   req_key0;
  logic [KEY_W-1:0]   req_key1;
  logic [1:0]         req_encdec;
  logic               core_rst;
  logic [BLOCK_W-1:0] core_block_i;
  logic [KEY_W-1:0]   core_key;
  logic               core_enc_dec;
  logic [BLOCK_W-1:0] core_block_o;
  logic               core_end;
  logic               resp_valid;
  logic               resp_ready;
  logic [BLOCK_W-1:0] resp_data;
  logic               resp_id;
  logic               resp_err;
  logic               busy;

  modport slave (
    input  req_valid, req_block0, req_block1, req_key0, req_key1, req_encdec,
    input  core_block_o, core_end, resp_ready,
    output req_ready, core_rst, core_block_i, core_key, core_enc_dec,
    output resp_valid, resp_data, resp_id, resp_err, busy
  );

  modport master (
    output req_valid, req_block0, req_block1, req_key0, req_key1, req_encdec,
    output core_block_o, core_end, resp_ready,
    input  req_ready, core_rst, core_block_i, core_key, core_enc_dec,
    input  resp_valid, resp_data, resp_id, resp_err, busy
  );

endinterface

// File: rtl/present_scheduler_arb.sv
// rtl/present_scheduler_arb.sv - two-way round-robin grant, pointer held by the caller
module rr_arbiter2 (
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = i_req_valid;
    if (&i_req_valid) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/present_scheduler.sv
// rtl/present_scheduler.sv - arbitrates two requesters onto one PRESENT core
// Optional RUN watchdog: PRESENT_SCHED_TIMEOUT_EN.
module present_scheduler
  import present_sched_pkg::*;
#(
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  present_scheduler_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  job_t               r_job;
  logic               r_last_grant;
  logic [3:0]         r_rst_cnt;
  logic [BLOCK_W-1:0] r_resp_data;
  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_sel;
  logic               w_timeout;

  rr_arbiter2 u_arb (
    .i_req_valid  (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_accept = (r_state == S_IDLE) && (|w_grant);
  assign w_sel    = w_grant[1];

`ifdef PRESENT_SCHED_TIMEOUT_EN
  logic [15:0] r_run_cnt;
  logic        r_resp_err;

  assign w_timeout    = (r_run_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign bus.resp_err = r_resp_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_cnt  <= '0;
      r_resp_err <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_run_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_run_cnt <= r_run_cnt + 16'd1;
      if (bus.core_end) begin
        r_resp_err <= 1'b0;
      end else if (w_timeout) begin
        r_resp_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout    = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 2'b00;
    bus.core_rst   = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = w_grant;
        bus.core_rst  = 1'b1;
        if (w_accept) w_next = S_LOAD;
      end
      S_LOAD: begin
        bus.core_rst = 1'b1;
        if (r_rst_cnt == 4'd0) w_next = S_RUN;
      end
      S_RUN: begin
        if (bus.core_end || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_job        <= '0;
      r_last_grant <= 1'b1;
      r_rst_cnt    <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_job <= '{block:  w_sel ? bus.req_block1 : bus.req_block0,
                       key:    w_sel ? bus.req_key1   : bus.req_key0,
                       encdec: bus.req_encdec[w_sel],
                       id:     w_sel};
            r_last_grant <= w_sel;
            r_rst_cnt    <= 4'(RST_CYCLES - 1);
          end
        end
        S_LOAD: begin
          if (r_rst_cnt != 4'd0) r_rst_cnt <= r_rst_cnt - 4'd1;
        end
        S_RUN: begin
          // A stale core_end can only be seen in IDLE/LOAD, so RUN trusts it
          if (bus.core_end) begin
            r_resp_data <= bus.core_block_o;
          end else if (w_timeout) begin
            r_resp_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.core_block_i = r_job.block;
  assign bus.core_key     = r_job.key;
  assign bus.core_enc_dec = r_job.encdec;
  assign bus.resp_data    = r_resp_data;
  assign bus.resp_id      = r_job.id;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_present_scheduler.sv
// tb/tb_present_scheduler.sv - directed bench for present_scheduler with a PRESENT core model
module tb_present_scheduler;
  import present_sched_pkg::*;

  localparam int CORE_LAT = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  present_scheduler_if bus ();

  present_scheduler #(.RST_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic core_en = 1'b1;
  int   core_cnt = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sbox_layer(input logic [63:0] s, input bit inv);
    logic [63:0] tbl;
    logic [63:0] r;
    tbl = inv ? 64'hA970364BD21C8FE5 : 64'h21748FE3DA09B65C;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = tbl[4*s[4*n +: 4] +: 4];
    return r;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s, input bit inv);
    logic [63:0] r;
    int p;
    for (int i = 0; i < 64; i++) begin
      p = (i == 63) ? 63 : (i * 16) % 63;
      if (inv) r[i] = s[p];
      else     r[p] = s[i];
    end
    return r;
  endfunction

  function automatic logic [63:0] present_model(input logic [63:0] blk, input logic [79:0] key,
                                                input bit enc);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    k = key;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      k = {k[18:0], k[79:19]};
      t = sbox_layer({60'd0, k[79:76]}, 1'b0);
      k[79:76] = t[3:0];
      k[19:15] = k[19:15] ^ 5'(i);
    end
    if (enc) begin
      s = blk;
      for (int i = 1; i <= 31; i++) s = p_layer(sbox_layer(s ^ rk[i], 1'b0), 1'b0);
      s = s ^ rk[32];
    end else begin
      s = blk ^ rk[32];
      for (int i = 31; i >= 1; i--) s = sbox_layer(p_layer(s, 1'b1), 1'b1) ^ rk[i];
    end
    return s;
  endfunction

  // Core model: synchronous reset, result after CORE_LAT cycles out of reset
  always @(posedge clk) begin
    logic rst_s;
    rst_s = bus.core_rst;
    #1;
    if (rst_s) begin
      core_cnt = 0;
      bus.core_end = 1'b0;
      bus.core_block_o = '0;
    end else if (!bus.core_end && core_en) begin
      core_cnt++;
      if (core_cnt == CORE_LAT) begin
        bus.core_end = 1'b1;
        bus.core_block_o = present_model(bus.core_block_i, bus.core_key, bus.core_enc_dec);
      end
    end
  end

  task automatic submit(input int id, input logic [63:0] blk, input logic [79:0] key, input bit enc);
    bit ok;
    ok = 0;
    if (id == 0) begin bus.req_block0 = blk; bus.req_key0 = key; end
    else         begin bus.req_block1 = blk; bus.req_key1 = key; end
    bus.req_encdec[id] = enc;
    bus.req_valid[id] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin ok = 1; break; end
    end
    if (!ok) check("accept_bound", 80'd0, 80'd1);
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(output int cycles);
    cycles = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.resp_valid) return;
    end
    check("resp_bound", 80'd0, 80'd1);
  endtask

  task automatic take_resp(input string tag, input logic [63:0] d, input logic id, input logic err);
    int c;
    wait_resp(c);
    check({tag, "_data"}, 80'(bus.resp_data), 80'(d));
    check({tag, "_id"},   80'(bus.resp_id),   80'(id));
    check({tag, "_err"},  80'(bus.resp_err),  80'(err));
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    int c;
    int run_cycles;
    logic [63:0] d0;
    bus.req_valid = '0; bus.req_encdec = '0; bus.resp_ready = 1'b0;
    bus.req_block0 = '0; bus.req_block1 = '0; bus.req_key0 = '0; bus.req_key1 = '0;
    bus.core_end = 1'b0; bus.core_block_o = '0;

    #12;
    check("rst_core_rst",  80'(bus.core_rst),     80'd1);
    check("rst_busy",      80'(bus.busy),         80'd0);
    check("rst_resp_vld",  80'(bus.resp_valid),   80'd0);
    check("rst_resp_data", 80'(bus.resp_data),    80'd0);
    check("rst_resp_id",   80'(bus.resp_id),      80'd0);
    check("rst_resp_err",  80'(bus.resp_err),     80'd0);
    check("rst_req_ready", 80'(bus.req_ready),    80'd0);
    check("rst_core_blk",  80'(bus.core_block_i), 80'd0);
    check("rst_core_key",  bus.core_key,          80'd0);
    check("rst_core_mode", 80'(bus.core_enc_dec), 80'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single job with accept-to-run and completion latency
    bus.req_block0 = '0; bus.req_key0 = '0; bus.req_encdec[0] = 1'b1; bus.req_valid[0] = 1'b1;
    @(negedge clk);
    check("single_ready", 80'(bus.req_ready), 80'd1);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("lat_t1_core_rst", 80'(bus.core_rst), 80'd1);
    check("lat_t1_busy",     80'(bus.busy),     80'd1);
    check("lat_t1_mode",     80'(bus.core_enc_dec), 80'd1);
    @(negedge clk);
    check("lat_t2_core_rst", 80'(bus.core_rst), 80'd1);
    @(negedge clk);
    check("lat_t3_core_rst", 80'(bus.core_rst), 80'd0);
    wait_resp(c);
    check("done_latency", 80'(c), 80'(CORE_LAT + 1));
    check("single_data", 80'(bus.resp_data), 80'h5579C1387B228445);
    check("single_id",   80'(bus.resp_id),   80'd0);
    check("single_err",  80'(bus.resp_err),  80'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;

    // Decrypt round trip
    submit(0, 64'h5579C1387B228445, 80'd0, 1'b0);
    take_resp("decrypt", 64'd0, 1'b0, 1'b0);

    // Contention from reset, then alternation under continuous requests
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    bus.req_block0 = '0; bus.req_key0 = '0;
    bus.req_block1 = '1; bus.req_key1 = '1;
    bus.req_encdec = 2'b11;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      take_resp($sformatf("rr%0d", k), (k % 2) ? 64'h3333DCD3213210D2 : 64'h5579C1387B228445,
                1'(k % 2), 1'b0);
    end
    bus.req_valid = 2'b00;

    // Backpressure: result held, pending requester stalled, one-cycle bubble
    submit(1, '1, '1, 1'b1);
    bus.req_block0 = 64'h5579C1387B228445; bus.req_key0 = '0; bus.req_encdec[0] = 1'b0;
    bus.req_valid[0] = 1'b1;
    wait_resp(c);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", 80'(bus.resp_valid), 80'd1);
      check("bp_data",  80'(bus.resp_data),  80'h3333DCD3213210D2);
      check("bp_id",    80'(bus.resp_id),    80'd1);
      check("bp_ready", 80'(bus.req_ready),  80'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    check("bp_next_ready", 80'(bus.req_ready), 80'd1);
    check("bp_next_busy",  80'(bus.busy),      80'd0);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_job_busy",  80'(bus.busy),         80'd1);
    check("bp_job_block", 80'(bus.core_block_i), 80'h5579C1387B228445);
    take_resp("bp_dec", 64'd0, 1'b0, 1'b0);

    // Reset in the middle of RUN
    submit(0, '1, '1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.core_rst) break;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_resp_vld", 80'(bus.resp_valid), 80'd0);
    check("mid_rst_core_rst", 80'(bus.core_rst),   80'd1);
    check("mid_rst_busy",     80'(bus.busy),       80'd0);
    check("mid_rst_ready",    80'(bus.req_ready),  80'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    submit(1, '1, '1, 1'b1);
    take_resp("after_rst", 64'h3333DCD3213210D2, 1'b1, 1'b0);

`ifdef PRESENT_SCHED_TIMEOUT_EN
    core_en = 1'b0;
    submit(0, '0, '0, 1'b1);
    run_cycles = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
      if (bus.busy && !bus.core_rst) run_cycles++;
    end
    check("to_run_cycles", 80'(run_cycles),    80'd64);
    check("to_err",        80'(bus.resp_err),  80'd1);
    check("to_data",       80'(bus.resp_data), 80'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1 bus.resp_ready = 1'b0;
    core_en = 1'b1;
`else
    run_cycles = 0;
`endif

    d0 = run_cycles;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=%0d exp=finish", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
